int_cvt_wb_merge: RTL and testbench

- Downstream writeback stage for the int_to_int converter.
- Consumes the converter's out_reg/result_vld together with the instruction's dst_prec, dst_pos and destination register index.
- Merges two 16-bit half-word results aimed at the same destination into one full-word write, and buffers writes in a FIFO with a valid/ready handshake toward the register file.
- Back-pressures the issuer through in_ready, because the converter itself is combinational and cannot stall.

---
 rtl/int_cvt_wb_merge.sv | 214 +++++++++++++++++++++
 tb/tb_int_cvt_wb_merge.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_cvt_wb_merge.sv
`default_nettype none
// ============================================================================
//  Module   : int_cvt_wb_merge
//  Purpose  : Writeback stage behind the combinational int_to_int converter.
//             It pairs two 16-bit half-word results that target the same
//             register into one full-word write. Writes are queued in a small
//             FIFO toward the register file. in_ready throttles the issuer,
//             because the converter cannot stall.
//  Ports    : clk, rst_n            clock, async active-low reset
//             result_vld, out_reg   converter result and its valid
//             dst_prec, dst_pos     32/16-bit destination, half select
//             dst_idx               destination register index
//             flush                 push out any held half-word
//             in_ready              a result can be accepted this cycle
//             wb_vld/wb_ready       FIFO head handshake
//             wb_data/wb_be/wb_idx  FIFO head contents
//             wb_par                per-byte even parity (WB_BYTE_PARITY_EN)
//             pend_vld              a half-word is held in the merge register
//  Options  : `define WB_BYTE_PARITY_EN adds wb_par and stores it per entry.
//  Revision : 1.0  initial release
// ============================================================================
module int_cvt_wb_merge #(
  parameter int IDX_W    = 5,
  parameter int DEPTH    = 4,
  parameter int MERGE_TO = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             result_vld,
  input  logic [31:0]      out_reg,
  input  logic             dst_prec,
  input  logic             dst_pos,
  input  logic [IDX_W-1:0] dst_idx,
  input  logic             flush,
  output logic             in_ready,
  output logic             wb_vld,
  input  logic             wb_ready,
  output logic [31:0]      wb_data,
  output logic [3:0]       wb_be,
  output logic [IDX_W-1:0] wb_idx,
`ifdef WB_BYTE_PARITY_EN
  output logic [3:0]       wb_par,
`endif
  output logic             pend_vld
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(MERGE_TO + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [TW-1:0] TO_C    = TW'(MERGE_TO);

  typedef enum logic [0:0] {IDLE = 1'b0, PEND = 1'b1} state_t;

  typedef struct packed {
    logic [31:0]      data;
    logic [3:0]       be;
    logic [IDX_W-1:0] idx;
  } entry_t;

  function automatic entry_t make_entry(input logic [31:0] d, input logic [3:0] be,
                                        input logic [IDX_W-1:0] idx);
    entry_t e;
    e.data = d;
    e.be   = be;
    e.idx  = idx;
    return e;
  endfunction

  // A lone half-word is written in place with only its two bytes enabled.
  function automatic entry_t make_part(input logic hi, input logic [15:0] d,
                                       input logic [IDX_W-1:0] idx);
    return hi ? make_entry({d, 16'h0000}, 4'b1100, idx)
              : make_entry({16'h0000, d}, 4'b0011, idx);
  endfunction

  state_t           state, state_nx;
  logic [IDX_W-1:0] p_idx;
  logic             p_hi;
  logic [15:0]      p_data;
  logic [TW-1:0]    cnt, cnt_nx, cnt_inc;
  logic             load;
  logic [1:0]       npush;
  entry_t           e0, e1;

  logic [CW-1:0]    count, count_nx, free_cnt;
  logic [AW-1:0]    wr_ptr, wr_ptr1, rd_ptr;
  logic             accept, pop;
  logic [15:0]      half_in;
  entry_t           mem [DEPTH];
  entry_t           head;

  assign accept   = result_vld & in_ready;
  assign pop      = wb_vld & wb_ready;
  assign half_in  = dst_pos ? out_reg[31:16] : out_reg[15:0];
  assign free_cnt = DEPTH_C - count;
  assign wr_ptr1  = wr_ptr + AW'(1);
  // Counter saturates at the timeout value so a blocked flush keeps expiring.
  assign cnt_inc  = (cnt == TO_C) ? cnt : cnt + TW'(1);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    npush    = 2'd0;
    e0       = '0;
    e1       = '0;
    if (accept) begin
      if (dst_prec) begin
        if (state == PEND) begin
          e0    = make_part(p_hi, p_data, p_idx);
          e1    = make_entry(out_reg, 4'hF, dst_idx);
          npush = 2'd2;
        end else begin
          e0    = make_entry(out_reg, 4'hF, dst_idx);
          npush = 2'd1;
        end
        state_nx = IDLE;
      end else if (state == PEND && dst_idx == p_idx && dst_pos != p_hi) begin
        e0       = make_entry(dst_pos ? {half_in, p_data} : {p_data, half_in}, 4'hF, dst_idx);
        npush    = 2'd1;
        state_nx = IDLE;
      end else begin
        if (state == PEND) begin
          e0    = make_part(p_hi, p_data, p_idx);
          npush = 2'd1;
        end
        load     = 1'b1;
        cnt_nx   = '0;
        state_nx = PEND;
        // flush alongside an accept also drains the half just captured,
        // queued behind any partial displaced above.
        if (flush) begin
          if (state == PEND) begin
            e1    = make_part(dst_pos, half_in, dst_idx);
            npush = 2'd2;
          end else begin
            e0    = make_part(dst_pos, half_in, dst_idx);
            npush = 2'd1;
          end
          state_nx = IDLE;
        end
      end
    end else if (state == PEND) begin
      cnt_nx = cnt_inc;
      if ((flush || cnt_inc == TO_C) && free_cnt != '0) begin
        e0       = make_part(p_hi, p_data, p_idx);
        npush    = 2'd1;
        state_nx = IDLE;
      end
    end
  end

  assign count_nx = count + CW'(npush) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      p_idx    <= '0;
      p_hi     <= 1'b0;
      p_data   <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_ready <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (load) begin
        p_idx  <= dst_idx;
        p_hi   <= dst_pos;
        p_data <= half_in;
      end
      count    <= count_nx;
      wr_ptr   <= wr_ptr + AW'(npush);
      rd_ptr   <= rd_ptr + AW'(pop);
      // Two free slots guarantee any single accept can be absorbed.
      in_ready <= (count_nx <= DEPTH_C - CW'(2));
    end
  end

  always_ff @(posedge clk) begin
    if (npush != 2'd0) mem[wr_ptr]  <= e0;
    if (npush == 2'd2) mem[wr_ptr1] <= e1;
  end

  assign head     = mem[rd_ptr];
  assign wb_vld   = (count != '0);
  // Outputs are forced to zero when empty so reset shows no stale entry.
  assign wb_data  = wb_vld ? head.data : '0;
  assign wb_be    = wb_vld ? head.be   : '0;
  assign wb_idx   = wb_vld ? head.idx  : '0;
  assign pend_vld = (state == PEND);

`ifdef WB_BYTE_PARITY_EN
  function automatic logic [3:0] byte_par(input entry_t e);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = e.be[i] & (^e.data[8*i +: 8]);
    return p;
  endfunction

  logic [3:0] mem_par [DEPTH];

  always_ff @(posedge clk) begin
    if (npush != 2'd0) mem_par[wr_ptr]  <= byte_par(e0);
    if (npush == 2'd2) mem_par[wr_ptr1] <= byte_par(e1);
  end

  assign wb_par = wb_vld ? mem_par[rd_ptr] : 4'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_int_cvt_wb_merge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_int_cvt_wb_merge
//  Purpose  : Directed self-checking bench for int_cvt_wb_merge. It runs a
//             queue-based reference model that is compared with the DUT
//             every cycle, plus literal expectations for the key scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_int_cvt_wb_merge;
  localparam int IDX_W    = 5;
  localparam int DEPTH    = 4;
  localparam int MERGE_TO = 8;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             result_vld = 1'b0, dst_prec = 1'b0, dst_pos = 1'b0;
  logic             flush = 1'b0, wb_ready = 1'b0;
  logic [31:0]      out_reg = '0;
  logic [IDX_W-1:0] dst_idx = '0;
  logic             in_ready, wb_vld, pend_vld;
  logic [31:0]      wb_data;
  logic [3:0]       wb_be;
  logic [IDX_W-1:0] wb_idx;
`ifdef WB_BYTE_PARITY_EN
  logic [3:0]       wb_par;
`endif

  int checks = 0;
  int errors = 0;

  int_cvt_wb_merge #(.IDX_W(IDX_W), .DEPTH(DEPTH), .MERGE_TO(MERGE_TO)) dut (
    .clk(clk), .rst_n(rst_n), .result_vld(result_vld), .out_reg(out_reg),
    .dst_prec(dst_prec), .dst_pos(dst_pos), .dst_idx(dst_idx), .flush(flush),
    .in_ready(in_ready), .wb_vld(wb_vld), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_be(wb_be), .wb_idx(wb_idx),
`ifdef WB_BYTE_PARITY_EN
    .wb_par(wb_par),
`endif
    .pend_vld(pend_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0]      data;
    logic [3:0]       be;
    logic [IDX_W-1:0] idx;
  } wr_t;

  wr_t              q[$];
  bit               pv, phi, m_rdy;
  logic [IDX_W-1:0] pidx;
  logic [15:0]      pdat;
  int               age;

  function automatic wr_t mk(input logic [31:0] d, input logic [3:0] be, input logic [IDX_W-1:0] i);
    wr_t w;
    w.data = d; w.be = be; w.idx = i;
    return w;
  endfunction

  function automatic wr_t part_of(input bit hi, input logic [15:0] d, input logic [IDX_W-1:0] i);
    return hi ? mk({d, 16'h0}, 4'b1100, i) : mk({16'h0, d}, 4'b0011, i);
  endfunction

  task automatic model_reset();
    q.delete();
    pv = 0; phi = 0; pidx = '0; pdat = '0; age = 0; m_rdy = 1;
  endtask

  // Effect of one clock edge given the inputs now applied.
  task automatic model_step();
    wr_t         add[$];
    int          free = DEPTH - q.size();
    bit          had  = q.size() > 0;
    logic [15:0] h    = dst_pos ? out_reg[31:16] : out_reg[15:0];
    if (result_vld && m_rdy) begin
      if (dst_prec) begin
        if (pv) add.push_back(part_of(phi, pdat, pidx));
        add.push_back(mk(out_reg, 4'hF, dst_idx));
        pv = 0;
      end else if (pv && pidx == dst_idx && phi != dst_pos) begin
        add.push_back(mk(dst_pos ? {h, pdat} : {pdat, h}, 4'hF, dst_idx));
        pv = 0;
      end else begin
        if (pv) add.push_back(part_of(phi, pdat, pidx));
        pv = 1; phi = dst_pos; pdat = h; pidx = dst_idx; age = 0;
        if (flush) begin
          add.push_back(part_of(phi, pdat, pidx));
          pv = 0;
        end
      end
    end else if (pv) begin
      if (age < MERGE_TO) age++;
      if ((flush || age == MERGE_TO) && free >= 1) begin
        add.push_back(part_of(phi, pdat, pidx));
        pv = 0;
      end
    end
    if (had && wb_ready) void'(q.pop_front());
    foreach (add[i]) q.push_back(add[i]);
    m_rdy = (DEPTH - q.size()) >= 2;
  endtask

  task automatic compare();
    if (!rst_n) begin
      model_reset();
      chk("rst_wb_data", wb_data, 32'h0);
      chk("rst_wb_be", wb_be, 4'h0);
      chk("rst_wb_idx", wb_idx, '0);
    end
    chk("in_ready", in_ready, m_rdy);
    chk("wb_vld", wb_vld, q.size() > 0);
    chk("pend_vld", pend_vld, pv);
    if (q.size() > 0) begin
      chk("wb_data", wb_data, q[0].data);
      chk("wb_be", wb_be, q[0].be);
      chk("wb_idx", wb_idx, q[0].idx);
`ifdef WB_BYTE_PARITY_EN
      begin
        logic [3:0] ep;
        for (int b = 0; b < 4; b++) ep[b] = q[0].be[b] & (^q[0].data[8*b +: 8]);
        chk("wb_par", wb_par, ep);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      compare();
      if (rst_n) model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input bit prec, input bit pos, input logic [31:0] d,
                      input logic [IDX_W-1:0] idx, input bit fl);
    int n = 0;
    @(posedge clk); #1;
    result_vld = 1; dst_prec = prec; dst_pos = pos; out_reg = d; dst_idx = idx; flush = fl;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("send_wait_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    result_vld = 0; flush = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic head_is(input string name, input logic [31:0] d, input logic [3:0] be,
                         input logic [IDX_W-1:0] idx);
    chk({name, "_vld"}, wb_vld, 1'b1);
    chk({name, "_data"}, wb_data, d);
    chk({name, "_be"}, wb_be, be);
    chk({name, "_idx"}, wb_idx, idx);
  endtask

  initial begin
    cyc(2);
    chk("reset_wb_vld", wb_vld, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_pend_vld", pend_vld, 1'b0);
    rst_n = 1; wb_ready = 1;
    cyc(2);

    // Full-word path
    send(1, 0, 32'h7FFF_FFFF, 5'd3, 0);
    head_is("full", 32'h7FFF_FFFF, 4'hF, 5'd3);
    cyc(2);

    // Merge low then high, same index
    send(0, 0, 32'hABCD_8000, 5'd5, 0);
    chk("merge_pend_mid", pend_vld, 1'b1);
    chk("merge_no_write_mid", wb_vld, 1'b0);
    send(0, 1, 32'h7FFF_1111, 5'd5, 0);
    head_is("merge", 32'h7FFF_8000, 4'hF, 5'd5);
    chk("merge_pend_after", pend_vld, 1'b0);
    cyc(2);

    // Pending high half displaced by a full word
    send(0, 1, 32'h1234_5678, 5'd2, 0);
    send(1, 0, 32'hDEAD_BEEF, 5'd7, 0);
    head_is("conflict0", 32'h1234_0000, 4'b1100, 5'd2);
    cyc(1);
    head_is("conflict1", 32'hDEAD_BEEF, 4'hF, 5'd7);
    cyc(2);

    // Timeout: exactly MERGE_TO cycles after capture
    send(0, 0, 32'hFFFF_00AB, 5'd1, 0);
    cyc(MERGE_TO - 1);
    chk("timeout_not_yet", wb_vld, 1'b0);
    chk("timeout_pend_held", pend_vld, 1'b1);
    cyc(1);
    head_is("timeout", 32'h0000_00AB, 4'b0011, 5'd1);
    chk("timeout_pend_clr", pend_vld, 1'b0);
    cyc(2);

    // Early flush
    send(0, 0, 32'h0000_00CD, 5'd4, 0);
    cyc(1);
    flush = 1;
    cyc(1);
    flush = 0;
    head_is("flush", 32'h0000_00CD, 4'b0011, 5'd4);
    cyc(2);

    // flush with a conflicting half: two pushes, older partial first
    send(0, 0, 32'h0000_1111, 5'd6, 0);
    send(0, 1, 32'h2222_0000, 5'd9, 1);
    head_is("flushacc0", 32'h0000_1111, 4'b0011, 5'd6);
    chk("flushacc_pend", pend_vld, 1'b0);
    cyc(1);
    head_is("flushacc1", 32'h2222_0000, 4'b1100, 5'd9);
    cyc(2);

    // Back-pressure
    wb_ready = 0;
    send(1, 0, 32'hA000_0001, 5'd10, 0);
    send(1, 0, 32'hA000_0002, 5'd11, 0);
    send(1, 0, 32'hA000_0003, 5'd12, 0);
    chk("bp_in_ready_low", in_ready, 1'b0);
    result_vld = 1; dst_prec = 1; out_reg = 32'hA000_0004; dst_idx = 5'd13;
    cyc(3);
    chk("bp_still_low", in_ready, 1'b0);
    head_is("bp_head_hold", 32'hA000_0001, 4'hF, 5'd10);
    wb_ready = 1;
    begin
      int n = 0;
      while (!in_ready && n < 20) begin cyc(1); n++; end
    end
    chk("bp_ready_back", in_ready, 1'b1);
    cyc(1);
    result_vld = 0;
    cyc(6);
    chk("bp_drained", wb_vld, 1'b0);

    // Async reset mid-PEND with three queued entries
    wb_ready = 0;
    send(1, 0, 32'hB000_0001, 5'd1, 0);
    send(1, 0, 32'hB000_0002, 5'd2, 0);
    send(0, 0, 32'h0000_3333, 5'd8, 0);
    send(0, 0, 32'h0000_4444, 5'd9, 0);
    chk("pre_rst_pend", pend_vld, 1'b1);
    rst_n = 0;
    #1;
    chk("arst_wb_vld", wb_vld, 1'b0);
    chk("arst_wb_data", wb_data, 32'h0);
    chk("arst_wb_be", wb_be, 4'h0);
    chk("arst_pend", pend_vld, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    cyc(2);
    rst_n = 1; wb_ready = 1;
    repeat (5) begin
      cyc(1);
      chk("post_rst_no_write", wb_vld, 1'b0);
    end

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
